bootrom_arbiter: RTL and testbench

- Shares the single-port synchronous boot ROM (512 x 32, 1-cycle registered read) between the CPU instruction-fetch bus (ibus) and data-load bus (dbus).
- Arbitrates per cycle, drives the ROM word address, and tags each issued read so the returned word is steered to the correct requester one cycle later.
- Range-checks the byte address, flags out-of-range accesses and supplies zero data for them.
- Sits between the aq32 core's bus splitter and the boot ROM instance.

---
 rtl/aq32_bus_pkg.sv | 17 +
 rtl/bootrom_arbiter_if.sv | 12 +
 rtl/bootrom_addr_check.sv | 18 +
 rtl/bootrom_arbiter.sv | 94 +++++++++
 tb/tb_bootrom_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/aq32_bus_pkg.sv
// rtl/aq32_bus_pkg.sv - shared bus types for the aq32 boot ROM path
package aq32_bus_pkg;

  typedef enum logic {
    REQ_IBUS = 1'b0,
    REQ_DBUS = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    err;
  } rom_tag_t;

  localparam int ROM_DEPTH_LOG2 = 9;

endpackage

// File: rtl/bootrom_arbiter_if.sv
// rtl/bootrom_arbiter_if.sv - one requester's read bus into the boot ROM arbiter
interface bootrom_arbiter_if;
  logic [31:0] addr;
  logic        req;
  logic        ack;
  logic        rdvalid;
  logic [31:0] rddata;
  logic        err;

  modport master (output addr, req, input ack, rdvalid, rddata, err);
  modport slave  (input addr, req, output ack, rdvalid, rddata, err);
endinterface

// File: rtl/bootrom_addr_check.sv
// rtl/bootrom_addr_check.sv - byte address to ROM word address and range flag
module bootrom_addr_check #(
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]       addr_i,
  output logic [ADDR_W-1:0] word_o,
  output logic              in_range_o
);
  logic        borrow;
  logic [29:0] offset_w;

  // Subtract at word granularity; the borrow keeps it exact for an unaligned base.
  assign borrow     = (addr_i[1:0] < BASE_ADDR[1:0]);
  assign offset_w   = addr_i[31:2] - BASE_ADDR[31:2] - {29'd0, borrow};
  assign word_o     = offset_w[ADDR_W-1:0];
  assign in_range_o = (offset_w[29:ADDR_W] == '0);
endmodule

// File: rtl/bootrom_arbiter.sv
// rtl/bootrom_arbiter.sv - shares the boot ROM between ibus and dbus
// BOOTROM_ARB_RR_EN selects round-robin arbitration instead of fixed ibus priority.
module bootrom_arbiter
  import aq32_bus_pkg::*;
#(
  parameter int          ADDR_W    = ROM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  bootrom_arbiter_if.slave   ibus,
  bootrom_arbiter_if.slave   dbus,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [31:0]        rom_rddata
);
  logic [ADDR_W-1:0] i_word, d_word;
  logic              i_in_range, d_in_range;
  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  rom_tag_t          tag_q, tag_d;
  logic [31:0]       i_data_q, i_data_d, d_data_q, d_data_d;
  logic              i_pulse, d_pulse;
  logic [31:0]       ret_data;

  bootrom_addr_check #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_ichk (
    .addr_i(ibus.addr), .word_o(i_word), .in_range_o(i_in_range)
  );
  bootrom_addr_check #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_dchk (
    .addr_i(dbus.addr), .word_o(d_word), .in_range_o(d_in_range)
  );

`ifdef BOOTROM_ARB_RR_EN
  req_id_e ptr_q, ptr_d;

  always_comb begin
    grant_i = rst_n & ibus.req & (~dbus.req | (ptr_q == REQ_IBUS));
    grant_d = rst_n & dbus.req & (~ibus.req | (ptr_q == REQ_DBUS));
    ptr_d   = ptr_q;
    if (rst_n && ibus.req && dbus.req)
      ptr_d = (ptr_q == REQ_IBUS) ? REQ_DBUS : REQ_IBUS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= REQ_IBUS;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_i = rst_n & ibus.req;
    grant_d = rst_n & dbus.req & ~ibus.req;
  end
`endif

  always_comb begin
    tag_d       = '0;
    tag_d.valid = grant_i | grant_d;
    tag_d.id    = grant_d ? REQ_DBUS : REQ_IBUS;
    tag_d.err   = grant_d ? ~d_in_range : (grant_i & ~i_in_range);
    rom_addr_d  = grant_d ? d_word : (grant_i ? i_word : rom_addr_q);
  end

  // Return side works off the tag captured at accept; reset masks it immediately.
  always_comb begin
    i_pulse  = rst_n & tag_q.valid & (tag_q.id == REQ_IBUS);
    d_pulse  = rst_n & tag_q.valid & (tag_q.id == REQ_DBUS);
    ret_data = tag_q.err ? 32'd0 : rom_rddata;
    i_data_d = i_pulse ? ret_data : i_data_q;
    d_data_d = d_pulse ? ret_data : d_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q      <= '0;
      rom_addr_q <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
    end else begin
      tag_q      <= tag_d;
      rom_addr_q <= rom_addr_d;
      i_data_q   <= i_data_d;
      d_data_q   <= d_data_d;
    end
  end

  assign rom_addr     = rom_addr_d;
  assign ibus.ack     = grant_i;
  assign dbus.ack     = grant_d;
  assign ibus.rdvalid = i_pulse;
  assign dbus.rdvalid = d_pulse;
  assign ibus.err     = i_pulse & tag_q.err;
  assign dbus.err     = d_pulse & tag_q.err;
  assign ibus.rddata  = i_data_d;
  assign dbus.rddata  = d_data_d;
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb/tb_bootrom_arbiter.sv - directed self-checking bench for bootrom_arbiter
module tb_bootrom_arbiter;
  logic        clk;
  logic        rst_n;
  logic [8:0]  rom_addr;
  logic [31:0] rom_rddata;
  logic [31:0] rom [512];
  int          total;
  int          bad;

  bootrom_arbiter_if ib ();
  bootrom_arbiter_if db ();

  bootrom_arbiter #(.ADDR_W(9), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ibus(ib), .dbus(db),
    .rom_addr(rom_addr), .rom_rddata(rom_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_rddata <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    logic        exp_i, exp_d, prev_i, prev_d;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 512; i++) rom[i] = 32'hC0DE_0000 | i;
    rom[2]   = 32'h0008_0117;
    rom[23]  = 32'hFF00_07B7;
    rom[24]  = 32'h3410_0713;
    rom[25]  = 32'h00E7_9023;
    rom[511] = 32'h0000_0000;
    b2b_addr[0] = 32'h5C; b2b_addr[1] = 32'h60; b2b_addr[2] = 32'h64;
    b2b_data[0] = 32'hFF00_07B7; b2b_data[1] = 32'h3410_0713; b2b_data[2] = 32'h00E7_9023;

    rst_n = 1'b0; ib.req = 1'b1; db.req = 1'b1; ib.addr = '0; db.addr = '0;
    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("rst_iack", ib.ack, 0);
      chk("rst_dack", db.ack, 0);
      chk("rst_ivalid", ib.rdvalid, 0);
      chk("rst_dvalid", db.rdvalid, 0);
      chk("rst_idata", ib.rddata, 0);
      chk("rst_ddata", db.rddata, 0);
    end
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_iack", ib.ack, 1);
    chk("rel_dack", db.ack, 0);
    cyc(); ib.req = 1'b0; db.req = 1'b0;
    @(negedge clk);
    chk("rel_ivalid", ib.rdvalid, 1);
    chk("rel_idata", ib.rddata, rom[0]);

    cyc(); ib.addr = 32'h8; ib.req = 1'b1;
    @(negedge clk);
    chk("fetch_ack", ib.ack, 1);
    chk("fetch_romaddr", {23'd0, rom_addr}, 2);
    cyc(); ib.req = 1'b0;
    @(negedge clk);
    chk("fetch_valid", ib.rdvalid, 1);
    chk("fetch_data", ib.rddata, 32'h0008_0117);
    chk("fetch_err", ib.err, 0);
    chk("fetch_dvalid", db.rdvalid, 0);
    cyc();
    @(negedge clk);
    chk("fetch_valid_end", ib.rdvalid, 0);
    chk("fetch_data_hold", ib.rddata, 32'h0008_0117);
    chk("romaddr_hold", {23'd0, rom_addr}, 2);

    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) begin db.req = 1'b1; db.addr = b2b_addr[k]; end
      else db.req = 1'b0;
      @(negedge clk);
      if (k < 3) chk("b2b_ack", db.ack, 1);
      if (k > 0) begin
        chk("b2b_valid", db.rdvalid, 1);
        chk("b2b_data", db.rddata, b2b_data[k-1]);
        chk("b2b_ivalid", ib.rdvalid, 0);
      end
    end
    cyc();
    @(negedge clk);
    chk("b2b_valid_end", db.rdvalid, 0);

    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    ib.addr = 32'h10; db.addr = 32'h20;
    prev_i = 1'b0; prev_d = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      ib.req = (k < 6);
      db.req = 1'b1;
`ifdef BOOTROM_ARB_RR_EN
      exp_i = (k < 6) && (k % 2 == 0);
      exp_d = (k < 6) ? (k % 2 == 1) : 1'b1;
`else
      exp_i = (k < 6);
      exp_d = (k == 6);
`endif
      @(negedge clk);
      chk("cont_iack", ib.ack, exp_i);
      chk("cont_dack", db.ack, exp_d);
      chk("cont_romaddr", {23'd0, rom_addr}, exp_i ? 32'd4 : 32'd8);
      if (k > 0) begin
        chk("cont_ivalid", ib.rdvalid, prev_i);
        chk("cont_dvalid", db.rdvalid, prev_d);
      end
      prev_i = exp_i; prev_d = exp_d;
    end
    cyc(); ib.req = 1'b0; db.req = 1'b0;
    @(negedge clk);
    chk("cont_last_dvalid", db.rdvalid, 1);
    chk("cont_last_ddata", db.rddata, rom[8]);
    chk("cont_last_ivalid", ib.rdvalid, 0);

    cyc(); db.addr = 32'h800; db.req = 1'b1;
    @(negedge clk);
    chk("oor_ack", db.ack, 1);
    cyc(); db.addr = 32'h7FC;
    @(negedge clk);
    chk("oor_valid", db.rdvalid, 1);
    chk("oor_err", db.err, 1);
    chk("oor_data", db.rddata, 0);
    chk("edge_ack", db.ack, 1);
    chk("edge_romaddr", {23'd0, rom_addr}, 511);
    cyc(); db.req = 1'b0;
    @(negedge clk);
    chk("edge_valid", db.rdvalid, 1);
    chk("edge_err", db.err, 0);
    chk("edge_data", db.rddata, 0);
    cyc();
    @(negedge clk);
    chk("edge_valid_end", db.rdvalid, 0);
    chk("edge_err_end", db.err, 0);

    cyc(); ib.addr = 32'h8; ib.req = 1'b1;
    @(negedge clk);
    chk("mid_ack", ib.ack, 1);
    cyc(); ib.req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ib.rdvalid, 0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_valid", ib.rdvalid, 0);
    chk("mid_after_data", ib.rddata, 0);
    cyc();
    @(negedge clk);
    chk("mid_late_valid", ib.rdvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
